// File: rtl/branch_unit.sv
// branch_unit: resolves jumps/branches, returns target and link, and holds a fetch redirect until acked.
// Define BRANCH_UNIT_STATS_EN to build the saturating total/taken statistics counters.
package arriskv_pkg;
    typedef enum logic [3:0] {
        INSTR_NOP, INSTR_ALU, INSTR_LOAD, INSTR_STORE,
        INSTR_JAL, INSTR_JALR, INSTR_BEQ, INSTR_BNE,
        INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU
    } instr_t;
endpackage

module branch_unit
    import arriskv_pkg::*;
#(
    parameter int wd_regs_p = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  instr_t               i_instr,
    input  logic [wd_regs_p-1:0] i_pc,
    input  logic [wd_regs_p-1:0] i_arg1,
    input  logic [wd_regs_p-1:0] i_arg2,
    input  logic [wd_regs_p-1:0] i_imm,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_br_taken,
    output logic [wd_regs_p-1:0] o_target,
    output logic [wd_regs_p-1:0] o_link,
    output logic                 o_misaligned,
    output logic                 o_redirect,
    input  logic                 i_redirect_ack,
    output logic [31:0]          o_cnt_total,
    output logic [31:0]          o_cnt_taken
);
    typedef enum logic [1:0] {IDLE, RESP, REDIRECT} state_t;

    state_t                 state, state_nx;
    logic                   taken_q, mis_q, accept, cond, mis;
    logic [wd_regs_p-1:0]   target_q, link_q, pc4, jalr_sum, dest;

    assign o_valid      = state == RESP;
    assign o_redirect   = state == REDIRECT;
    assign o_br_taken   = taken_q;
    assign o_misaligned = mis_q;
    assign o_target     = target_q;
    assign o_link       = link_q;
    assign o_ready      = state == IDLE || (state == RESP && i_ready && !taken_q);
    assign accept       = i_valid && o_ready && !i_flush;

    assign pc4      = i_pc + wd_regs_p'(4);
    assign jalr_sum = i_arg1 + i_imm;
    assign dest     = i_instr == INSTR_JALR ? {jalr_sum[wd_regs_p-1:1], 1'b0} : i_pc + i_imm;
    assign mis      = cond && dest[1:0] != 2'b00;

    always_comb begin
        cond = i_instr == INSTR_JAL  || i_instr == INSTR_JALR ? 1'b1 :
               i_instr == INSTR_BEQ  ? i_arg1 == i_arg2 :
               i_instr == INSTR_BNE  ? i_arg1 != i_arg2 :
               i_instr == INSTR_BLT  ? $signed(i_arg1) <  $signed(i_arg2) :
               i_instr == INSTR_BGE  ? $signed(i_arg1) >= $signed(i_arg2) :
               i_instr == INSTR_BLTU ? i_arg1 <  i_arg2 :
               i_instr == INSTR_BGEU ? i_arg1 >= i_arg2 : 1'b0;
        state_nx = i_flush          ? IDLE :
                   state == IDLE    ? (accept ? RESP : IDLE) :
                   state == RESP    ? (!i_ready ? RESP : taken_q ? REDIRECT : accept ? RESP : IDLE) :
                   i_redirect_ack   ? IDLE : REDIRECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            taken_q  <= 1'b0;
            mis_q    <= 1'b0;
            target_q <= '0;
            link_q   <= '0;
        end else begin
            state <= state_nx;
            if (i_flush) begin
                taken_q <= 1'b0;
                mis_q   <= 1'b0;
            end else if (accept) begin
                taken_q  <= cond && !mis;
                mis_q    <= mis;
                target_q <= cond && !mis ? dest : pc4;
                link_q   <= pc4;
            end
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] cnt_total, cnt_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total <= '0;
            cnt_taken <= '0;
        end else if (o_valid && i_ready) begin
            cnt_total <= cnt_total + {31'd0, ~&cnt_total};
            if (taken_q)
                cnt_taken <= cnt_taken + {31'd0, ~&cnt_taken};
        end
    end

    assign o_cnt_total = cnt_total;
    assign o_cnt_taken = cnt_taken;
`else
    assign o_cnt_total = '0;
    assign o_cnt_taken = '0;
`endif
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed and randomized checks of branch_unit against a behavioural model.
module tb_branch_unit;
    import arriskv_pkg::*;

    logic        clk = 0, rst_n = 0, i_valid = 0, i_ready = 0, i_flush = 0, i_redirect_ack = 0;
    instr_t      i_instr = INSTR_NOP;
    logic [31:0] i_pc = 0, i_arg1 = 0, i_arg2 = 0, i_imm = 0;
    logic        o_ready, o_valid, o_br_taken, o_misaligned, o_redirect;
    logic [31:0] o_target, o_link, o_cnt_total, o_cnt_taken;
    int          n_vec = 0, n_err = 0;

    branch_unit #(.wd_regs_p(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
        .i_pc(i_pc), .i_arg1(i_arg1), .i_arg2(i_arg2), .i_imm(i_imm), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_br_taken(o_br_taken), .o_target(o_target),
        .o_link(o_link), .o_misaligned(o_misaligned), .o_redirect(o_redirect),
        .i_redirect_ack(i_redirect_ack), .o_cnt_total(o_cnt_total), .o_cnt_taken(o_cnt_taken)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // {taken, misaligned, target, link} from the architectural rules
    function automatic logic [65:0] model(instr_t op, logic [31:0] pc, a1, a2, imm);
        logic        t;
        logic [31:0] d;
        case (op)
            INSTR_JAL, INSTR_JALR: t = 1;
            INSTR_BEQ:  t = a1 == a2;
            INSTR_BNE:  t = a1 != a2;
            INSTR_BLT:  t = $signed(a1) <  $signed(a2);
            INSTR_BGE:  t = $signed(a1) >= $signed(a2);
            INSTR_BLTU: t = a1 <  a2;
            INSTR_BGEU: t = a1 >= a2;
            default:    t = 0;
        endcase
        d = op == INSTR_JALR ? (a1 + imm) & 32'hFFFF_FFFE : pc + imm;
        if (t && d % 4 != 0) return {1'b0, 1'b1, pc + 32'd4, pc + 32'd4};
        return {t, 1'b0, t ? d : pc + 32'd4, pc + 32'd4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input instr_t op, input logic [31:0] pc, a1, a2, imm);
        i_instr = op; i_pc = pc; i_arg1 = a1; i_arg2 = a2; i_imm = imm; i_valid = 1;
        for (int k = 0; k < 20 && !o_ready; k++) tick();
        tick();
        i_valid = 0;
    endtask

    task automatic finish_resp();
        i_ready = 1;
        tick();
        i_ready = 0;
        for (int k = 0; k < 20 && o_redirect; k++) begin
            i_redirect_ack = 1;
            tick();
        end
        i_redirect_ack = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(); tick();
        n_vec++;
        if ({o_valid, o_br_taken, o_misaligned, o_redirect, o_target, o_link, o_cnt_total, o_cnt_taken} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b t=%b m=%b r=%b tgt=%h lnk=%h ct=%h ck=%h want all zero",
                     o_valid, o_br_taken, o_misaligned, o_redirect, o_target, o_link, o_cnt_total, o_cnt_taken);
        end
        rst_n = 1;
        n_vec++;
        if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", o_ready); end
        issue(INSTR_JAL, 32'h80, 0, 0, 32'h40);
        i_ready = 1;
        tick();
        i_ready = 0;
        #2 rst_n = 0;
        #1;
        n_vec++;
        if ({o_redirect, o_valid, o_br_taken, o_target} !== '0) begin
            n_err++;
            $display("FAIL reset_abandon: got r=%b v=%b t=%b tgt=%h want 0", o_redirect, o_valid, o_br_taken, o_target);
        end
        tick();
        rst_n = 1;
        n_vec++;
        if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_abandon_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_directed();
        instr_t      ops[5] = '{INSTR_BLT, INSTR_BLTU, INSTR_JALR, INSTR_JAL, INSTR_JAL};
        logic [31:0] pcs[5] = '{32'h100, 32'h100, 32'h50, 32'h200, 32'hFFFF_FFFC};
        logic [31:0] a1s[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1001, 0, 0};
        logic [31:0] a2s[5] = '{1, 1, 0, 0, 0};
        logic [31:0] ims[5] = '{32'h20, 32'h20, 32'h4, 32'h6, 32'h8};
        logic        tks[5] = '{1, 0, 1, 0, 1};
        logic        mss[5] = '{0, 0, 0, 1, 0};
        logic [31:0] tgs[5] = '{32'h120, 32'h104, 32'h1004, 32'h204, 32'h4};
        logic [31:0] lks[5] = '{32'h104, 32'h104, 32'h54, 32'h204, 32'h0};
        for (int i = 0; i < 5; i++) begin
            i_ready = 0;
            issue(ops[i], pcs[i], a1s[i], a2s[i], ims[i]);
            n_vec++;
            if ({o_valid, o_br_taken, o_misaligned, o_target, o_link} !== {1'b1, tks[i], mss[i], tgs[i], lks[i]}) begin
                n_err++;
                $display("FAIL directed_%0d: got v=%b t=%b m=%b tgt=%h lnk=%h want v=1 t=%b m=%b tgt=%h lnk=%h",
                         i, o_valid, o_br_taken, o_misaligned, o_target, o_link, tks[i], mss[i], tgs[i], lks[i]);
            end
            i_ready = 1;
            tick();
            i_ready = 0;
            for (int j = 0; j < 3 && tks[i]; j++) begin
                n_vec++;
                if ({o_redirect, o_ready, o_valid, o_target} !== {3'b100, tgs[i]}) begin
                    n_err++;
                    $display("FAIL directed_redirect_%0d: got r=%b rdy=%b v=%b tgt=%h want r=1 rdy=0 v=0 tgt=%h",
                             i, o_redirect, o_ready, o_valid, o_target, tgs[i]);
                end
                tick();
            end
            i_redirect_ack = tks[i];
            tick();
            i_redirect_ack = 0;
            n_vec++;
            if ({o_redirect, o_valid, o_ready} !== 3'b001) begin
                n_err++;
                $display("FAIL directed_idle_%0d: got r=%b v=%b rdy=%b want r=0 v=0 rdy=1", i, o_redirect, o_valid, o_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            instr_t      op  = instr_t'($urandom_range(0, 11));
            logic [31:0] pc  = $urandom & 32'hFFFF_FFFC;
            logic [31:0] a1  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 4);
            logic [31:0] a2  = $urandom_range(0, 3) == 0 ? a1 : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 4));
            logic [31:0] imm = $urandom_range(0, 3) != 0 ? $urandom & 32'hFFFF_FFFC : $urandom;
            logic [65:0] exp = model(op, pc, a1, a2, imm);
            i_ready = 0;
            issue(op, pc, a1, a2, imm);
            for (int s = 0; s <= int'($urandom_range(0, 2)); s++) begin
                n_vec++;
                if ({o_valid, o_br_taken, o_misaligned, o_target, o_link} !== {1'b1, exp}) begin
                    n_err++;
                    $display("FAIL random_%0d op=%0d: got v=%b t=%b m=%b tgt=%h lnk=%h want v=1 %h",
                             i, op, o_valid, o_br_taken, o_misaligned, o_target, o_link, exp);
                end
                i_pc = $urandom; i_arg1 = $urandom; i_imm = $urandom;
                if (s == 0) continue;
                tick();
            end
            i_ready = 1;
            tick();
            i_ready = 0;
            n_vec++;
            if (o_redirect !== exp[65]) begin
                n_err++;
                $display("FAIL random_redirect_%0d: got %b want %b", i, o_redirect, exp[65]);
            end
            repeat ($urandom_range(0, 2)) tick();
            i_redirect_ack = 1;
            tick();
            i_redirect_ack = 0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        i_ready = 1;
        i_instr = INSTR_BNE; i_arg1 = 32'h55; i_arg2 = 32'h55; i_imm = 32'h100;
        i_pc = 32'h1000; i_valid = 1;
        for (int i = 0; i < 6; i++) begin
            prev = i_pc;
            tick();
            i_pc = prev + 32'h10;
            n_vec++;
            if ({o_valid, o_ready, o_br_taken, o_target, o_link} !== {3'b110, prev + 32'd4, prev + 32'd4}) begin
                n_err++;
                $display("FAIL back_to_back_%0d: got v=%b rdy=%b t=%b tgt=%h lnk=%h want v=1 rdy=1 t=0 tgt=lnk=%h",
                         i, o_valid, o_ready, o_br_taken, o_target, o_link, prev + 32'd4);
            end
        end
        i_valid = 0;
        tick();
        i_ready = 0;
        n_vec++;
        if (o_valid !== 1'b0) begin n_err++; $display("FAIL back_to_back_drain: got v=%b want 0", o_valid); end
    endtask

    task automatic test_flush();
        i_ready = 0;
        issue(INSTR_JAL, 32'h300, 0, 0, 32'h10);
        i_ready = 1;
        tick();
        i_ready = 0;
        n_vec++;
        if (o_redirect !== 1'b1) begin n_err++; $display("FAIL flush_pre_redirect: got %b want 1", o_redirect); end
        i_flush = 1;
        tick();
        i_flush = 0;
        n_vec++;
        if ({o_redirect, o_valid, o_br_taken, o_misaligned, o_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL flush_redirect: got r=%b v=%b t=%b m=%b rdy=%b want r=0 v=0 t=0 m=0 rdy=1",
                     o_redirect, o_valid, o_br_taken, o_misaligned, o_ready);
        end
        issue(INSTR_BEQ, 32'h400, 1, 2, 32'h8);
        i_ready = 1; i_valid = 1; i_flush = 1;
        tick();
        i_ready = 0; i_valid = 0; i_flush = 0;
        n_vec++;
        if ({o_valid, o_redirect, o_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL flush_beats_accept: got v=%b r=%b rdy=%b want v=0 r=0 rdy=1", o_valid, o_redirect, o_ready);
        end
    endtask

    task automatic test_stall();
        i_ready = 0;
        issue(INSTR_BGE, 32'h400, 5, 5, 32'h40);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({o_valid, o_br_taken, o_misaligned, o_ready, o_target, o_link} !== {4'b1100, 32'h440, 32'h404}) begin
                n_err++;
                $display("FAIL stall_%0d: got v=%b t=%b m=%b rdy=%b tgt=%h lnk=%h want v=1 t=1 m=0 rdy=0 tgt=440 lnk=404",
                         i, o_valid, o_br_taken, o_misaligned, o_ready, o_target, o_link);
            end
            i_valid = 1; i_instr = INSTR_JAL; i_pc = $urandom; i_imm = $urandom;
            tick();
        end
        i_valid = 0;
        finish_resp();
    endtask

    task automatic test_stats();
        logic [31:0] want_tot, want_tk;
`ifdef BRANCH_UNIT_STATS_EN
        want_tot = 5; want_tk = 3;
`else
        want_tot = 0; want_tk = 0;
`endif
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            i_ready = 0;
            if (i < 3) issue(INSTR_JAL, 32'h10 * i, 0, 0, 32'h10);
            else issue(INSTR_BEQ, 32'h10 * i, 1, 2, 32'h10);
            finish_resp();
        end
        n_vec++;
        if ({o_cnt_total, o_cnt_taken} !== {want_tot, want_tk}) begin
            n_err++;
            $display("FAIL stats: got total=%0d taken=%0d want total=%0d taken=%0d", o_cnt_total, o_cnt_taken, want_tot, want_tk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_stall();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
